// File: rtl/fb_pkg.sv
// Shared constants and types for the framebuffer write arbiter.
// The clear engine is only built when FB_CLEAR_EN is defined.
package fb_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int H_W          = 10;
    localparam int V_W          = 9;
    localparam int ADDR_W       = H_W + V_W;
    localparam int DW           = 24;

    typedef logic [DW-1:0] pixel_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    function automatic logic [ADDR_W-1:0] fb_addr(input logic [H_W-1:0] h,
                                                  input logic [V_W-1:0] v);
        return {h, v};
    endfunction

endpackage

// File: rtl/fb_write_arb_rr_arb2.sv
// Two-input round-robin arbiter; the pointer moves on every granted transfer.
// Reset leaves the pointer so that requester 0 wins the first tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

    logic last_gnt;

    always_comb begin
        grant = 2'b00;
        if (en) begin
            case (valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_gnt ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    // grant is already gated by valid, so any grant is a transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt <= 1'b1;
        end else if (|grant) begin
            last_gnt <= grant[1];
        end
    end

endmodule

// File: rtl/fb_write_arb.sv
// Framebuffer write-port controller: round-robin pixel writer plus clear engine.
// Define FB_CLEAR_EN to build the clear engine; otherwise clr_* are ignored.
//
// state | meaning
// IDLE  | requesters arbitrated, accepted in-range pixels written
// CLEAR | sweep visible area with fill colour, requesters held off
module fb_write_arb #(
    parameter int H_ACTIVE = fb_pkg::H_ACTIVE_DEF,
    parameter int V_ACTIVE = fb_pkg::V_ACTIVE_DEF,
    parameter int DW       = fb_pkg::DW
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      req0_valid,
    output logic                      req0_ready,
    input  logic [9:0]                req0_h,
    input  logic [8:0]                req0_v,
    input  logic [DW-1:0]             req0_data,
    input  logic                      req1_valid,
    output logic                      req1_ready,
    input  logic [9:0]                req1_h,
    input  logic [8:0]                req1_v,
    input  logic [DW-1:0]             req1_data,
    input  logic                      clr_start,
    input  logic [DW-1:0]             clr_color,
    output logic                      clr_busy,
    output logic                      wr_en,
    output logic [fb_pkg::ADDR_W-1:0] wr_addr,
    output logic [DW-1:0]             wr_data
);
    import fb_pkg::*;

    localparam logic [H_W:0] H_LIM = (H_W+1)'(H_ACTIVE);
    localparam logic [V_W:0] V_LIM = (V_W+1)'(V_ACTIVE);

    state_t         state;
    logic           clr_go;
    logic [H_W-1:0] clr_h;
    logic [V_W-1:0] clr_v;
    logic [DW-1:0]  fill;

`ifdef FB_CLEAR_EN
    localparam logic [H_W-1:0] H_LAST = H_W'(H_ACTIVE - 1);
    localparam logic [V_W-1:0] V_LAST = V_W'(V_ACTIVE - 1);

    assign clr_go = clr_start && (state == IDLE);

    // v is the inner loop so consecutive clear writes walk down a column
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            clr_h <= '0;
            clr_v <= '0;
            fill  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr_start) begin
                        state <= CLEAR;
                        fill  <= clr_color;
                        clr_h <= '0;
                        clr_v <= '0;
                    end
                end
                CLEAR: begin
                    if (clr_v == V_LAST) begin
                        clr_v <= '0;
                        if (clr_h == H_LAST) begin
                            clr_h <= '0;
                            state <= IDLE;
                        end else begin
                            clr_h <= clr_h + 1'b1;
                        end
                    end else begin
                        clr_v <= clr_v + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    logic unused_clr;

    assign unused_clr = ^{clr_start, clr_color};
    assign clr_go     = 1'b0;
    assign state      = IDLE;
    assign clr_h      = '0;
    assign clr_v      = '0;
    assign fill       = '0;
`endif

    assign clr_busy = (state == CLEAR);

    logic [1:0]     grant;
    logic           arb_en;
    logic           xfer;
    logic [H_W-1:0] sel_h;
    logic [V_W-1:0] sel_v;
    logic [DW-1:0]  sel_data;
    logic           in_range;

    assign arb_en = (state == IDLE) && !clr_go;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (resetn),
        .en    (arb_en),
        .valid ({req1_valid, req0_valid}),
        .grant (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign xfer       = |grant;

    always_comb begin
        sel_h    = req0_h;
        sel_v    = req0_v;
        sel_data = req0_data;
        if (grant[1]) begin
            sel_h    = req1_h;
            sel_v    = req1_v;
            sel_data = req1_data;
        end
    end

    assign in_range = ({1'b0, sel_h} < H_LIM) && ({1'b0, sel_v} < V_LIM);

    // out-of-range pixels are accepted but never reach the write port
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else if (state == CLEAR) begin
            wr_en   <= 1'b1;
            wr_addr <= fb_addr(clr_h, clr_v);
            wr_data <= fill;
        end else if (xfer && in_range) begin
            wr_en   <= 1'b1;
            wr_addr <= fb_addr(sel_h, sel_v);
            wr_data <= sel_data;
        end else begin
            wr_en   <= 1'b0;
        end
    end

endmodule
